// File: rtl/wb_sram_bist_pkg.sv
// Shared types and March C- element table for the Wishbone SRAM BIST master.
package wb_sram_bist_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_GAP  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  typedef enum logic [2:0] {
    EL_E0 = 3'd0,
    EL_E1 = 3'd1,
    EL_E2 = 3'd2,
    EL_E3 = 3'd3,
    EL_E4 = 3'd4,
    EL_E5 = 3'd5
  } elem_e;

  localparam logic [31:0] D0 = 32'h0000_0000;
  localparam logic [31:0] D1 = 32'hFFFF_FFFF;

  typedef struct packed {
    logic        down;
    logic        has_rd;
    logic        has_wr;
    logic [31:0] rd_exp;
    logic [31:0] wr_dat;
  } elem_cfg_t;

  function automatic elem_cfg_t elem_cfg(input elem_e e);
    elem_cfg_t c;
    case (e)
      EL_E0:   c = '{down: 1'b0, has_rd: 1'b0, has_wr: 1'b1, rd_exp: D0, wr_dat: D0};
      EL_E1:   c = '{down: 1'b0, has_rd: 1'b1, has_wr: 1'b1, rd_exp: D0, wr_dat: D1};
      EL_E2:   c = '{down: 1'b0, has_rd: 1'b1, has_wr: 1'b1, rd_exp: D1, wr_dat: D0};
      EL_E3:   c = '{down: 1'b1, has_rd: 1'b1, has_wr: 1'b1, rd_exp: D0, wr_dat: D1};
      EL_E4:   c = '{down: 1'b1, has_rd: 1'b1, has_wr: 1'b1, rd_exp: D1, wr_dat: D0};
      EL_E5:   c = '{down: 1'b0, has_rd: 1'b1, has_wr: 1'b0, rd_exp: D0, wr_dat: D0};
      default: c = '{down: 1'b0, has_rd: 1'b0, has_wr: 1'b1, rd_exp: D0, wr_dat: D0};
    endcase
    return c;
  endfunction

  function automatic elem_e elem_next(input elem_e e);
    elem_e n;
    case (e)
      EL_E0:   n = EL_E1;
      EL_E1:   n = EL_E2;
      EL_E2:   n = EL_E3;
      EL_E3:   n = EL_E4;
      EL_E4:   n = EL_E5;
      EL_E5:   n = EL_E0;
      default: n = EL_E0;
    endcase
    return n;
  endfunction

  function automatic logic elem_is_down(input elem_e e);
    elem_cfg_t c;
    c = elem_cfg(e);
    return c.down;
  endfunction

endpackage

// File: rtl/wb_sram_bist_seq.sv
// Element/op/index sequencer: describes the current access and steps to the next one on adv.
module wb_sram_bist_seq
  import wb_sram_bist_pkg::*;
#(
  parameter int DEPTH = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        adv,
  output logic [9:0]  idx,
  output logic        we,
  output logic [31:0] wr_dat,
  output logic [31:0] rd_exp,
  output logic        last
);

  localparam logic [9:0] LAST_IDX = 10'(DEPTH - 1);

  elem_e      elem_r;
  logic       op_r;
  logic [9:0] idx_r;
  elem_cfg_t  cfg_s;
  logic       nxt_down_s;
  logic       last_op_s;
  logic       last_idx_s;

  // Decode the current element and detect element/index boundaries.
  always_comb begin
    cfg_s      = elem_cfg(elem_r);
    nxt_down_s = elem_is_down(elem_next(elem_r));
    last_op_s  = !(cfg_s.has_rd && cfg_s.has_wr) || op_r;
    if (cfg_s.down) begin
      last_idx_s = (idx_r == 10'd0);
    end else begin
      last_idx_s = (idx_r == LAST_IDX);
    end
  end

  // op 0 is the read whenever the element has one; the write always follows it.
  assign idx    = idx_r;
  assign we     = !cfg_s.has_rd || op_r;
  assign wr_dat = cfg_s.wr_dat;
  assign rd_exp = cfg_s.rd_exp;
  assign last   = (elem_r == EL_E5) && last_op_s && last_idx_s;

  // Counter update: op first, then index, then element with index reload for its direction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      elem_r <= EL_E0;
      op_r   <= 1'b0;
      idx_r  <= 10'd0;
    end else if (clear) begin
      elem_r <= EL_E0;
      op_r   <= 1'b0;
      idx_r  <= 10'd0;
    end else if (adv) begin
      if (!last_op_s) begin
        op_r <= 1'b1;
      end else begin
        op_r <= 1'b0;
        if (!last_idx_s) begin
          idx_r <= cfg_s.down ? (idx_r - 10'd1) : (idx_r + 10'd1);
        end else begin
          elem_r <= elem_next(elem_r);
          idx_r  <= nxt_down_s ? LAST_IDX : 10'd0;
        end
      end
    end
  end

endmodule

// File: rtl/wb_sram_bist.sv
// March C- Wishbone BIST master for the 1024x32 SRAM window.
// Optional ack timeout: define WB_SRAM_BIST_TIMEOUT_EN.
module wb_sram_bist
  import wb_sram_bist_pkg::*;
#(
  parameter logic [31:0] ADDR_BASE = 32'h0000_8000,
  parameter int          DEPTH     = 1024,
  parameter int          TIMEOUT   = 63
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        start_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        pass_o,
  output logic        timeout_o,
  output logic [9:0]  fail_addr_o,
  output logic [31:0] fail_data_o,
  output logic        m_cyc_o,
  output logic        m_stb_o,
  output logic        m_we_o,
  output logic [3:0]  m_sel_o,
  output logic [31:0] m_adr_o,
  output logic [31:0] m_dat_o,
  input  logic [31:0] m_dat_i,
  input  logic        m_ack_i
);

  state_e      state_r;
  logic        start_q_r;
  logic        final_r;
  logic        busy_r;
  logic        done_r;
  logic        pass_r;
  logic [9:0]  fail_addr_r;
  logic [31:0] fail_data_r;
  logic        cyc_r;
  logic        we_r;
  logic [31:0] adr_r;
  logic [31:0] dat_r;

  logic        start_rise_s;
  logic        seq_clear_s;
  logic        seq_adv_s;
  logic [9:0]  seq_idx_s;
  logic        seq_we_s;
  logic [31:0] seq_wr_dat_s;
  logic [31:0] seq_rd_exp_s;
  logic        seq_last_s;
  logic [31:0] next_adr_s;

`ifdef WB_SRAM_BIST_TIMEOUT_EN
  logic        timeout_r;
  logic [15:0] wait_r;
  assign timeout_o = timeout_r;
`else
  logic        unused_timeout_s;
  assign unused_timeout_s = (TIMEOUT != 0);
  assign timeout_o        = 1'b0;
`endif

  assign start_rise_s = start_i && !start_q_r;
  assign seq_clear_s  = start_rise_s && ((state_r == ST_IDLE) || (state_r == ST_DONE));
  assign seq_adv_s    = (state_r == ST_BUS) && m_ack_i;
  assign next_adr_s   = ADDR_BASE + {20'd0, seq_idx_s, 2'b00};

  assign busy_o      = busy_r;
  assign done_o      = done_r;
  assign pass_o      = pass_r;
  assign fail_addr_o = fail_addr_r;
  assign fail_data_o = fail_data_r;
  assign m_cyc_o     = cyc_r;
  assign m_stb_o     = cyc_r;
  assign m_we_o      = we_r;
  assign m_sel_o     = 4'hF;
  assign m_adr_o     = adr_r;
  assign m_dat_o     = dat_r;

  wb_sram_bist_seq #(.DEPTH(DEPTH)) u_seq (
    .clk    (wb_clk_i),
    .rst    (wb_rst_i),
    .clear  (seq_clear_s),
    .adv    (seq_adv_s),
    .idx    (seq_idx_s),
    .we     (seq_we_s),
    .wr_dat (seq_wr_dat_s),
    .rd_exp (seq_rd_exp_s),
    .last   (seq_last_s)
  );

  // Test FSM, Wishbone handshake, read compare and status latching.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_r     <= ST_IDLE;
      start_q_r   <= 1'b0;
      final_r     <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      pass_r      <= 1'b0;
      fail_addr_r <= 10'd0;
      fail_data_r <= 32'd0;
      cyc_r       <= 1'b0;
      we_r        <= 1'b0;
      adr_r       <= ADDR_BASE;
      dat_r       <= 32'd0;
`ifdef WB_SRAM_BIST_TIMEOUT_EN
      timeout_r   <= 1'b0;
      wait_r      <= 16'd0;
`endif
    end else begin
      start_q_r <= start_i;
      case (state_r)
        ST_IDLE, ST_DONE: begin
          // First access is always E0 w(D0) at word 0.
          if (start_rise_s) begin
            busy_r      <= 1'b1;
            done_r      <= 1'b0;
            pass_r      <= 1'b0;
            fail_addr_r <= 10'd0;
            fail_data_r <= 32'd0;
            final_r     <= 1'b0;
            cyc_r       <= 1'b1;
            we_r        <= 1'b1;
            adr_r       <= ADDR_BASE;
            dat_r       <= D0;
`ifdef WB_SRAM_BIST_TIMEOUT_EN
            timeout_r   <= 1'b0;
            wait_r      <= 16'd0;
`endif
            state_r     <= ST_BUS;
          end
        end
        ST_BUS: begin
          if (m_ack_i) begin
            cyc_r   <= 1'b0;
            final_r <= seq_last_s;
            if (!seq_we_s && (m_dat_i != seq_rd_exp_s)) begin
              fail_addr_r <= seq_idx_s;
              fail_data_r <= m_dat_i;
              pass_r      <= 1'b0;
              done_r      <= 1'b1;
              busy_r      <= 1'b0;
              state_r     <= ST_DONE;
            end else begin
              state_r <= ST_GAP;
            end
          end
`ifdef WB_SRAM_BIST_TIMEOUT_EN
          else if (wait_r == 16'(TIMEOUT - 1)) begin
            cyc_r       <= 1'b0;
            timeout_r   <= 1'b1;
            pass_r      <= 1'b0;
            fail_addr_r <= seq_idx_s;
            fail_data_r <= 32'd0;
            done_r      <= 1'b1;
            busy_r      <= 1'b0;
            state_r     <= ST_DONE;
          end else begin
            wait_r <= wait_r + 16'd1;
          end
`endif
        end
        ST_GAP: begin
          // Sequencer already stepped on the ack edge, so its outputs describe the next access.
          if (final_r) begin
            pass_r  <= 1'b1;
            done_r  <= 1'b1;
            busy_r  <= 1'b0;
            state_r <= ST_DONE;
          end else begin
            cyc_r   <= 1'b1;
            we_r    <= seq_we_s;
            adr_r   <= next_adr_s;
            dat_r   <= seq_we_s ? seq_wr_dat_s : 32'd0;
`ifdef WB_SRAM_BIST_TIMEOUT_EN
            wait_r  <= 16'd0;
`endif
            state_r <= ST_BUS;
          end
        end
        default: begin
          cyc_r   <= 1'b0;
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_sram_bist.sv
// Self-checking bench: reactive SRAM slave with fault injection and an element-level March C- reference.
module tb_wb_sram_bist;

  localparam int          DEPTH   = 1024;
  localparam logic [31:0] BASE    = 32'h0000_8000;
  localparam int          TMO     = 63;
  localparam int          ALIAS_A = 16;
  localparam int          ALIAS_B = 17;

  localparam int EL_DOWN [6] = '{0, 0, 0, 1, 1, 0};
  localparam int EL_RD   [6] = '{-1, 0, 1, 0, 1, 0};
  localparam int EL_WR   [6] = '{0, 1, 0, 1, 0, -1};

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        busy_o, done_o, pass_o, timeout_o;
  logic [9:0]  fail_addr_o;
  logic [31:0] fail_data_o;
  logic        m_cyc_o, m_stb_o, m_we_o;
  logic [3:0]  m_sel_o;
  logic [31:0] m_adr_o, m_dat_o;
  logic [31:0] m_dat_i = 32'd0;
  logic        m_ack_i = 1'b0;

  always #5 clk = ~clk;

  wb_sram_bist #(.ADDR_BASE(BASE), .DEPTH(DEPTH), .TIMEOUT(TMO)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .start_i(start),
    .busy_o(busy_o), .done_o(done_o), .pass_o(pass_o), .timeout_o(timeout_o),
    .fail_addr_o(fail_addr_o), .fail_data_o(fail_data_o),
    .m_cyc_o(m_cyc_o), .m_stb_o(m_stb_o), .m_we_o(m_we_o), .m_sel_o(m_sel_o),
    .m_adr_o(m_adr_o), .m_dat_o(m_dat_o), .m_dat_i(m_dat_i), .m_ack_i(m_ack_i)
  );

  typedef struct {
    int          idx;
    bit          we;
    logic [31:0] dat;
  } acc_t;

  int          n_cmp = 0;
  int          n_bad = 0;
  acc_t        exp_q[$];
  logic [31:0] mem [2][DEPTH];
  int          fmode = 0;
  int          fa = 0;
  int          fb = 0;
  bit          fv = 1'b0;
  int          lat_max = 1;
  int          cnt = 1;
  int          acc_cnt = 0;
  int          seq_err = 0;
  bit          slave_en = 1'b1;
  int          ref_n;
  bit          ref_fail;
  int          ref_fidx;
  logic [31:0] ref_fdat;

  // Fault model shared by the slave memory (index 0) and the reference memory (index 1).
  function automatic int phys(input int a);
    return (fmode == 2 && a == ALIAS_B) ? ALIAS_A : a;
  endfunction

  function automatic void mwrite(input int s, input int a, input logic [31:0] d);
    int p;
    p = phys(a);
    mem[s][p] = d;
    if (fmode == 1 && p == fa) mem[s][p][fb] = fv;
  endfunction

  function automatic logic [31:0] mread(input int s, input int a);
    return mem[s][phys(a)];
  endfunction

  function automatic int new_lat();
    return (lat_max <= 1) ? 1 : int'($urandom_range(1, lat_max));
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // March C- as six element loops over a memory; stops at the first bad read.
  task automatic build_ref();
    int i;
    logic [31:0] v, ev;
    acc_t a;
    exp_q.delete();
    ref_n = 0; ref_fail = 1'b0; ref_fidx = 0; ref_fdat = 32'd0;
    for (int e = 0; e < 6; e++) begin
      for (int k = 0; k < DEPTH; k++) begin
        i = (EL_DOWN[e] == 1) ? (DEPTH - 1 - k) : k;
        if (EL_RD[e] >= 0) begin
          a.idx = i; a.we = 1'b0; a.dat = 32'd0;
          exp_q.push_back(a);
          ref_n++;
          ev = (EL_RD[e] == 1) ? 32'hFFFF_FFFF : 32'h0000_0000;
          v = mread(1, i);
          if (v !== ev) begin
            ref_fail = 1'b1; ref_fidx = i; ref_fdat = v;
            return;
          end
        end
        if (EL_WR[e] >= 0) begin
          a.idx = i; a.we = 1'b1;
          a.dat = (EL_WR[e] == 1) ? 32'hFFFF_FFFF : 32'h0000_0000;
          exp_q.push_back(a);
          ref_n++;
          mwrite(1, i, a.dat);
        end
      end
    end
  endtask

  task automatic setup_run(input int mode, input int a, input int b, input bit v, input int lm);
    logic [31:0] r;
    fmode = mode; fa = a; fb = b; fv = v; lat_max = lm;
    for (int i = 0; i < DEPTH; i++) begin
      r = $urandom;
      mem[0][i] = r;
      mem[1][i] = r;
    end
    if (mode == 1) begin
      mem[0][a][b] = v;
      mem[1][a][b] = v;
    end
    build_ref();
    acc_cnt = 0;
    seq_err = 0;
  endtask

  // Slave on the falling edge: ack after the chosen latency, then checks the GAP cycle.
  always @(negedge clk) begin : slave
    int idx;
    acc_t e;
    if (rst) begin
      m_ack_i = 1'b0;
      cnt = new_lat();
    end else if (m_ack_i) begin
      m_ack_i = 1'b0;
      if (m_cyc_o || m_stb_o) seq_err++;
      cnt = new_lat();
    end else if (slave_en && m_cyc_o && m_stb_o) begin
      if (cnt > 1) begin
        cnt--;
      end else begin
        idx = int'((m_adr_o - BASE) >> 2);
        if (m_sel_o !== 4'hF || m_adr_o < BASE || idx >= DEPTH || m_adr_o[1:0] != 2'b00) begin
          seq_err++;
        end else begin
          if (exp_q.size() == 0) begin
            seq_err++;
          end else begin
            e = exp_q.pop_front();
            if (e.idx != idx || e.we != m_we_o || (e.we && e.dat !== m_dat_o)) seq_err++;
          end
          if (m_we_o) mwrite(0, idx, m_dat_o);
          else m_dat_i = mread(0, idx);
        end
        acc_cnt++;
        m_ack_i = 1'b1;
      end
    end
  end

  task automatic start_pulse(input string tag);
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    #1;
    chk({tag, " cyc"}, m_cyc_o, 1);
    chk({tag, " we"}, m_we_o, 1);
    chk({tag, " adr"}, m_adr_o, BASE);
    chk({tag, " dat"}, m_dat_o, 32'h0);
    chk({tag, " busy"}, busy_o, 1);
    chk({tag, " done clr"}, done_o, 0);
    @(negedge clk) start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget, input bit toggle);
    int k;
    k = 0;
    while (!done_o && k < budget) begin
      @(negedge clk);
      k++;
      if (toggle && busy_o && $urandom_range(0, 39) == 0) start = ~start;
    end
    chk({tag, " done reached"}, done_o, 1);
    start = 1'b0;
  endtask

  task automatic check_result(input string tag);
    chk({tag, " done"}, done_o, 1);
    chk({tag, " busy"}, busy_o, 0);
    chk({tag, " cyc"}, m_cyc_o, 0);
    chk({tag, " pass"}, pass_o, {31'd0, !ref_fail});
    chk({tag, " timeout"}, timeout_o, 0);
    chk({tag, " fail_addr"}, fail_addr_o, ref_fidx);
    chk({tag, " fail_data"}, fail_data_o, ref_fdat);
    chk({tag, " accesses"}, acc_cnt, ref_n);
    chk({tag, " seq errors"}, seq_err, 0);
    chk({tag, " leftover"}, exp_q.size(), 0);
  endtask

  initial begin
    int r;
    int n;

    // Reset state
    #12;
    chk("rst busy", busy_o, 0);
    chk("rst done", done_o, 0);
    chk("rst pass", pass_o, 0);
    chk("rst timeout", timeout_o, 0);
    chk("rst fail_addr", fail_addr_o, 0);
    chk("rst fail_data", fail_data_o, 0);
    chk("rst cyc", m_cyc_o, 0);
    chk("rst stb", m_stb_o, 0);
    chk("rst we", m_we_o, 0);
    chk("rst sel", m_sel_o, 4'hF);
    chk("rst adr", m_adr_o, BASE);
    chk("rst dat", m_dat_o, 0);
    @(posedge clk) #2 rst = 1'b0;
    repeat (3) @(negedge clk);

    // Stuck-at-0 bit 5 at word 0x123, ack one cycle after stb
    setup_run(1, 'h123, 5, 1'b0, 1);
    start_pulse("A start");
    wait_done("A", 20000, 1'b0);
    check_result("A");
    chk("A fail_addr const", fail_addr_o, 10'h123);
    chk("A fail_data const", fail_data_o, 32'hFFFF_FFDF);

    // Restart from DONE with an address-decoder alias, random latency
    setup_run(2, 0, 0, 1'b0, 2);
    start_pulse("B start");
    wait_done("B", 20000, 1'b0);
    check_result("B");
    chk("B alias addr", (fail_addr_o == 10'd16) || (fail_addr_o == 10'd17), 1);

    // Random stuck-at cell with start_i toggled while busy
    r = $urandom_range(0, 255);
    n = $urandom_range(0, 31);
    setup_run(1, r, n, 1'($urandom_range(0, 1)), 2);
    start_pulse("C start");
    wait_done("C", 20000, 1'b1);
    check_result("C");

    // Reset in the middle of E3
    setup_run(0, 0, 0, 1'b0, 1);
    start_pulse("D start");
    r = 5120 + $urandom_range(1, 200);
    n = 0;
    while (acc_cnt < r && n < 25000) begin
      @(negedge clk);
      n++;
    end
    chk("D reached E3", acc_cnt >= r, 1);
    #2 rst = 1'b1;
    #1;
    chk("D rst cyc", m_cyc_o, 0);
    chk("D rst stb", m_stb_o, 0);
    chk("D rst busy", busy_o, 0);
    chk("D rst done", done_o, 0);
    chk("D rst pass", pass_o, 0);
    chk("D rst fail_addr", fail_addr_o, 0);
    chk("D rst fail_data", fail_data_o, 0);
    chk("D rst adr", m_adr_o, BASE);
    @(negedge clk);
    @(posedge clk) #2 rst = 1'b0;
    repeat (2) @(negedge clk);

    // Full passing test after the reset
    setup_run(0, 0, 0, 1'b0, 1);
    start_pulse("E start");
    wait_done("E", 40000, 1'b0);
    check_result("E");
    chk("E pass const", pass_o, 1);
    chk("E accesses const", acc_cnt, 10 * DEPTH);

    // Slave that never acks
    setup_run(0, 0, 0, 1'b0, 1);
    slave_en = 1'b0;
    start_pulse("T start");
`ifdef WB_SRAM_BIST_TIMEOUT_EN
    n = 0;
    while (m_cyc_o && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("T cycles to drop", n, TMO);
    chk("T done", done_o, 1);
    chk("T timeout", timeout_o, 1);
    chk("T pass", pass_o, 0);
    chk("T fail_addr", fail_addr_o, 0);
    chk("T fail_data", fail_data_o, 0);
    chk("T busy", busy_o, 0);
`else
    repeat (200) @(negedge clk);
    chk("T cyc held", m_cyc_o, 1);
    chk("T stb held", m_stb_o, 1);
    chk("T busy", busy_o, 1);
    chk("T done", done_o, 0);
    chk("T timeout", timeout_o, 0);
    chk("T accesses", acc_cnt, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
